// File: rtl/fibonacci_index_finder_if.sv
// Lookup bus for the Fibonacci index finder: request value/start in, search results out.
interface fibonacci_index_finder_if #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 5
);
    logic [WIDTH-1:0] value_in;
    logic             begin_find;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] index_out;
    logic [WIDTH-1:0] floor_out;
    logic             is_fibo;

    modport master (
        output value_in, begin_find,
        input  busy, done, index_out, floor_out, is_fibo
    );

    modport slave (
        input  value_in, begin_find,
        output busy, done, index_out, floor_out, is_fibo
    );
endinterface

// File: rtl/fibonacci_index_finder.sv
// Finds the largest n with F(n) <= V by walking the sequence one step per clock;
// reports n, F(n) and whether V is exactly a Fibonacci number.
module fibonacci_index_finder #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    fibonacci_index_finder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] v_q, v_d;
    // One extra bit so F(k+1) can exceed the largest WIDTH-bit value without wrapping.
    logic [WIDTH:0]   f_k_q, f_k_d;
    logic [WIDTH:0]   f_k1_q, f_k1_d;
    logic [IDX_W-1:0] k_q, k_d;
    logic             done_q, done_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [WIDTH-1:0] floor_q, floor_d;
    logic             is_fibo_q, is_fibo_d;
    logic             term;

    assign term = (f_k1_q > {1'b0, v_q});

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            v_q       <= '0;
            f_k_q     <= '0;
            f_k1_q    <= '0;
            k_q       <= '0;
            done_q    <= 1'b0;
            index_q   <= '0;
            floor_q   <= '0;
            is_fibo_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            v_q       <= v_d;
            f_k_q     <= f_k_d;
            f_k1_q    <= f_k1_d;
            k_q       <= k_d;
            done_q    <= done_d;
            index_q   <= index_d;
            floor_q   <= floor_d;
            is_fibo_q <= is_fibo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.begin_find) state_d = SEARCH;
            SEARCH:  if (term) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        v_d       = v_q;
        f_k_d     = f_k_q;
        f_k1_d    = f_k1_q;
        k_d       = k_q;
        done_d    = done_q;
        index_d   = index_q;
        floor_d   = floor_q;
        is_fibo_d = is_fibo_q;
        case (state_q)
            IDLE: begin
                if (bus.begin_find) begin
                    v_d    = bus.value_in;
                    f_k_d  = '0;
                    f_k1_d = {{WIDTH{1'b0}}, 1'b1};
                    k_d    = '0;
                    done_d = 1'b0;
                end
            end
            SEARCH: begin
                if (term) begin
                    index_d   = k_q;
                    floor_d   = f_k_q[WIDTH-1:0];
                    is_fibo_d = (f_k_q == {1'b0, v_q});
                    done_d    = 1'b1;
                end else begin
                    f_k_d  = f_k1_q;
                    f_k1_d = f_k_q + f_k1_q;
                    k_d    = k_q + 1'b1;
                end
            end
            DONE:    done_d = 1'b0;
            default: done_d = 1'b0;
        endcase
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.index_out = index_q;
    assign bus.floor_out = floor_q;
    assign bus.is_fibo   = is_fibo_q;
endmodule

// File: doc/fibonacci_index_finder.md
Name: fibonacci_index_finder

Overview:
- Inverse of the Fibonacci calculator: given a value V, finds the largest index n such that F(n) <= V.
- Reports n, F(n), and whether V is exactly a Fibonacci number.
- Iterative, one Fibonacci step per clock, start/done handshake.
- Sits alongside the calculator in the Fibonacci datapath; used for checking calculator results and for value-to-index lookup.

Parameters:
- WIDTH, 16, bit width of the input value and of floor_out.
- IDX_W, 5, bit width of index_out. Constraint: the largest n with F(n) <= 2^WIDTH-1 must fit in IDX_W bits (24 for the defaults).

Ports:
- clk  input  1  clock, all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- value_in  input  WIDTH  value to look up; sampled only when a start is accepted.
- begin_find  input  1  start request; accepted only in IDLE.
- busy  output  1  high whenever state != IDLE.
- done  output  1  registered single-cycle pulse; results are valid.
- index_out  output  IDX_W  largest n with F(n) <= V.
- floor_out  output  WIDTH  F(index_out).
- is_fibo  output  1  1 when F(index_out) == V.

Behaviour:
- Sequence convention: F(0)=0, F(1)=1, F(n)=F(n-1)+F(n-2).
  - Because F(1)=F(2)=1, V=1 reports n=2 (largest index).
- Reset (synchronous, reset=1 at an edge):
  - state=IDLE; done=0, index_out=0, floor_out=0, is_fibo=0; internal registers cleared.
  - Reset overrides every other condition, including mid-search; the aborted search produces no done pulse.
- Internal registers:
  - v_reg (WIDTH).
  - f_k (WIDTH+1).
  - f_k1 (WIDTH+1); the extra bit prevents overflow: F(25)=75025 > 65535.
  - k (IDX_W).
- State IDLE:
  - If begin_find=1: v_reg<=value_in, f_k<=0, f_k1<=1, k<=0, done<=0, go to SEARCH.
  - Otherwise hold. Outputs keep their previous results.
- State SEARCH, each cycle:
  - If f_k1 > v_reg (terminate): index_out<=k, floor_out<=f_k[WIDTH-1:0], is_fibo<=(f_k==v_reg), done<=1, go to DONE.
  - Else (step): f_k<=f_k1, f_k1<=f_k+f_k1, k<=k+1, stay in SEARCH.
- State DONE: done<=0, go to IDLE. Results hold until the next accepted start.
- Latency:
  - Accept edge, then exactly n+1 SEARCH edges; done is high for the single cycle following the final SEARCH edge.
  - Examples: V=0 takes 1 SEARCH edge; V=2^16-1 takes 25.
- begin_find while busy=1 (SEARCH or DONE) is ignored; no queuing.
- begin_find held high continuously: a new start is accepted in the first IDLE cycle after DONE, i.e. back-to-back operation with one IDLE cycle between runs.
- value_in changes after acceptance have no effect.
- index_out, floor_out and is_fibo update only on the terminating SEARCH edge, never mid-search.
- Arithmetic:
  - Unsigned throughout.
  - All comparisons are WIDTH+1 bits wide, with v_reg zero-extended.
  - k never wraps under the parameter constraint.

Test Plan:
- After reset: busy=0, done=0, index_out=0, floor_out=0, is_fibo=0. Pulse begin_find with value_in=0 -> done 1 edge after accept; index_out=0, floor_out=0, is_fibo=1.
- value_in=1 -> done 3 edges after accept; index_out=2, floor_out=1, is_fibo=1.
- value_in=13 -> done 8 edges after accept; index_out=7, floor_out=13, is_fibo=1. Then value_in=100 -> index_out=11, floor_out=89, is_fibo=0.
- value_in=46368 -> index_out=24, floor_out=46368, is_fibo=1. value_in=65535 -> index_out=24, floor_out=46368, is_fibo=0, done 25 edges after accept; no overflow.
- Start with 100; during SEARCH toggle value_in to 5 and pulse begin_find -> both ignored, result still 11/89/0. Hold begin_find high with value 5 -> next run accepted one cycle after DONE, giving index_out=5, is_fibo=1.
- Start with 65535; assert reset on the 10th SEARCH cycle -> next cycle state IDLE, busy=0, all outputs 0, no done pulse. A fresh start with 8 -> index_out=6, is_fibo=1.
